// File: rtl/spi_flash_init_loader.sv
// spi_flash_init_loader
//   Serves one-byte init_req fetches for the SDRAM power-up image copy by
//   reading an SPI NOR flash (READ 0x03, mode 0) at FLASH_BASE + init_address.
//   Consecutive addresses keep CS low and simply clock out the next byte.
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   init_req          one-cycle request, init_address valid on that cycle
//   init_address[21]  image byte address
//   init_stop[21]     constant IMAGE_LAST
//   init_data[8]      fetched byte, held until the next init_ready
//   init_ready        one-cycle pulse, init_data valid
//   spi_cs_n/sck/mosi flash select (active low), clock (idles low), cmd/addr out
//   spi_miso          flash data in
module spi_flash_init_loader #(
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter logic [20:0] IMAGE_LAST  = 21'h1FFFFF,
  parameter int          CLK_DIV     = 2,
  parameter int          CS_HIGH_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [20:0] init_address,
  output logic [20:0] init_stop,
  output logic [7:0]  init_data,
  output logic        init_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

  typedef enum logic [2:0] {S_DESEL, S_IDLE, S_CMD, S_DATA, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [CW-1:0] des_cnt;
  logic          sck, pend;
  logic [5:0]    bit_cnt;
  logic [31:0]   shift;
  logic [7:0]    rx;
  logic [20:0]   next_addr, pend_addr, load_addr;
  logic          stream_open;
  logic          shifting, phase_end, rise, fall, des_done, load, seq_hit, cmd_last, byte_done;

  assign init_stop = IMAGE_LAST;
  assign spi_sck   = sck;

  // SCK only runs while a command or data byte is in flight; elsewhere it is parked low.
  assign byte_done = (state == S_DATA) && (bit_cnt == 6'd8);
  assign shifting  = (state == S_CMD) || ((state == S_DATA) && !byte_done);
  assign phase_end = (div == DW'(CLK_DIV - 1));
  assign rise      = shifting && phase_end && !sck;
  assign fall      = shifting && phase_end && sck;
  assign cmd_last  = (state == S_CMD) && fall && (bit_cnt == 6'd31);
  assign des_done  = (des_cnt == CW'(CS_HIGH_CYC - 1));
  assign seq_hit   = stream_open && init_req && (init_address == next_addr);

  // A request parked while deselected (stream break or early req) starts on its own.
  assign load_addr = (state == S_DESEL && pend) ? pend_addr : init_address;
  assign load      = ((state == S_IDLE) && init_req) ||
                     ((state == S_DESEL) && des_done && (pend || init_req));

  always_ff @(posedge clk) begin
    if (rst) state <= S_DESEL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_DESEL: if (des_done) state_nxt = (pend || init_req) ? S_CMD : S_IDLE;
      S_IDLE:  if (init_req) state_nxt = S_CMD;
      S_CMD:   if (cmd_last) state_nxt = S_DATA;
      S_DATA:  if (byte_done) state_nxt = S_HOLD;
      S_HOLD:  if (init_req) state_nxt = seq_hit ? S_DATA : S_DESEL;
      default: state_nxt = S_DESEL;
    endcase
  end

  always_comb begin
    spi_cs_n    = 1'b1;
    spi_mosi    = 1'b0;
    stream_open = 1'b0;
    unique case (state)
      S_CMD:   begin spi_cs_n = 1'b0; spi_mosi = shift[31]; end
      S_DATA:  spi_cs_n = 1'b0;
      S_HOLD:  begin spi_cs_n = 1'b0; stream_open = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      sck        <= 1'b0;
      des_cnt    <= '0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx         <= '0;
      next_addr  <= '0;
      init_data  <= 8'h00;
      init_ready <= 1'b0;
    end else begin
      init_ready <= 1'b0;

      if (shifting) begin
        if (phase_end) begin
          div <= '0;
          sck <= !sck;
        end else begin
          div <= div + DW'(1);
        end
      end else begin
        div <= '0;
        sck <= 1'b0;
      end

      if (rise) rx <= {rx[6:0], spi_miso};
      // MOSI advances on the falling edge so it is stable across the next rise.
      if (fall) begin
        shift   <= {shift[30:0], 1'b0};
        bit_cnt <= cmd_last ? 6'd0 : bit_cnt + 6'd1;
      end

      if (state == S_DESEL) begin
        des_cnt <= des_done ? '0 : des_cnt + CW'(1);
        if (!des_done && init_req && !pend) begin
          pend      <= 1'b1;
          pend_addr <= init_address;
        end
      end

      if (byte_done) begin
        init_data  <= rx;
        init_ready <= 1'b1;
        bit_cnt    <= '0;
      end

      if (state == S_HOLD && init_req) begin
        if (seq_hit) begin
          next_addr <= next_addr + 21'd1;
          bit_cnt   <= '0;
        end else begin
          pend      <= 1'b1;
          pend_addr <= init_address;
          des_cnt   <= '0;
        end
      end

      if (load) begin
        shift     <= {8'h03, FLASH_BASE + {3'b000, load_addr}};
        next_addr <= load_addr + 21'd1;
        bit_cnt   <= '0;
        pend      <= 1'b0;
      end
    end
  end
endmodule
